vector_tile_assembler: RTL and testbench
========================================

# vector_tile_assembler

Assembles a 64-element vector tile from a narrow 8-lane input stream and presents it as one registered 64-element vector with a valid/ready handshake. It is the stage directly upstream of the slice unit: its `data_out[0:63]`/`valid_out`/`ready_out` connect straight to the slice unit's `data_in`/`valid_in`/`ready_in`. Two internal tile banks (ping-pong) let the next tile fill while the previous one waits for the consumer.

## Interface

Parameters:
- `DATA_WIDTH`, default from `npu_definitions.vh` (16): element width in bits.
- `IN_LANES`, default 8, fixed: elements per input beat. A full tile is 8 beats.

Ports:
- `clk` — input, 1 bit: single clock; all state changes on the rising edge.
- `rst` — input, 1 bit: asynchronous, active-high reset.
- `data_in[0:7]` — input, DATA_WIDTH each: input beat lanes.
- `valid_in` — input, 1 bit: beat valid.
- `last_in` — input, 1 bit: the current beat ends the tile early. Sampled only on an accepted beat.
- `ready_in` — output, 1 bit: assembler can accept a beat.
- `data_out[0:63]` — output, DATA_WIDTH each: assembled tile from the drain bank.
- `count_out` — output, 7 bits: number of valid elements in the presented tile (8..64, multiple of 8).
- `valid_out` — output, 1 bit: tile presented.
- `ready_out` — input, 1 bit: consumer accepts the tile.

## Operation

Storage:
- Two banks, each holding 64 elements, a 7-bit count, and a 1-bit FULL flag.
- `fill_sel` points to the bank being written. `drain_sel` points to the bank being presented.
- `beat_cnt` is 3 bits and gives the beat index within the filling tile.

Per-bank state (EMPTY / FULL):
- EMPTY → FULL: on an accepted beat with `beat_cnt==7` or `last_in==1`.
  - Set `count = (beat_cnt+1)*8`.
  - Clear `beat_cnt` to 0 and toggle `fill_sel`.
- FULL → EMPTY: on `valid_out && ready_out`. Toggle `drain_sel`.

Input path:
- `ready_in = !rst && !FULL[fill_sel]`. It depends only on registers, never on `valid_in`.
- Accept a beat when `valid_in && ready_in`.
- An accepted beat k writes `data_in[j]` to `bank[fill_sel][8k+j]` for j = 0..7.
- On beat 0 of a tile, elements 8..63 of that bank are cleared to zero. As a result, elements at index ≥ count always read as 0.
- `beat_cnt` increments by 1 on each accepted non-final beat.

Output path:
- `valid_out = FULL[drain_sel]`.
- `data_out` = contents of `bank[drain_sel]`; `count_out = count[drain_sel]`.
- While `valid_out && !ready_out`, `data_out` and `count_out` stay stable.
- When no tile is presented, `data_out` is the stale bank contents and `count_out` is 0.

Simultaneous events:
- Completing a fill and draining a tile in the same cycle is legal. Both banks update independently.
- If a fill completes into one bank while the other bank is being drained, `ready_in` stays high.
- If both banks are FULL, `ready_in` is low. It rises the cycle after the first handshake on `valid_out`/`ready_out`.

Reset (any time, including mid-tile):
- Both banks EMPTY, all counts 0, all data 0.
- `beat_cnt=0`, `fill_sel=0`, `drain_sel=0`.
- Any partially filled tile is discarded.
- Outputs: `valid_out=0`, `count_out=0`, `data_out` all 0, `ready_in=0` while `rst` is high and 1 the first cycle after release.

## Timing

- Latency: if the final beat is accepted at edge N, `valid_out` is high after edge N (visible in cycle N+1).
- Sustained input throughput: one beat per cycle, provided the consumer takes each tile within 8 cycles.
- Minimum tile period at output: 1 cycle per tile (back-to-back `valid_out` with `ready_out` tied high, given tiles arrive fast enough).
- Accepted `last_in` with `beat_cnt==7` is identical to a normal full tile (count 64).
- `last_in` on a beat that is not accepted has no effect.

## Test plan

- **Single full tile:** reset, then 8 consecutive beats with element value = global index 0..63, `ready_out=1`.
  - Required: `valid_out` high exactly one cycle, in the cycle after beat 7.
  - `data_out[i]==i`; `count_out==64`.
- **Early termination:** 3 beats, third with `last_in=1`.
  - Required: `count_out==24`; `data_out[0..23]` match input; `data_out[24..63]==0`.
  - This holds even when the bank previously held a full nonzero tile.
- **Backpressure:** `ready_out=0`, stream 3 full tiles continuously.
  - Required: tiles 1 and 2 are accepted; `ready_in` falls after the 16th beat.
  - `data_out` holds tile 1 unchanged.
  - Raise `ready_out` for one cycle: tile 2 is presented next cycle and `ready_in` returns high.
- **Simultaneous fill/drain:** arrange the final beat of tile B in the same cycle as the handshake on `valid_out`/`ready_out` for tile A.
  - Required: tile B is presented the next cycle, with no bubble and no lost beat.
- **Reset mid-tile:** assert `rst` after 5 beats.
  - Required: `ready_in=0` and `valid_out=0` immediately (asynchronous).
  - After release, a new 8-beat tile is presented with correct data and `count_out==64`; no trace of the partial tile.
- **Ready independence:** toggle `valid_in` randomly while both banks are FULL.
  - Required: `ready_in` stays 0, and no bank contents change.

Source files
------------

// File: rtl/vector_tile_assembler_if.sv
// Beat-in / tile-out bus of the vector tile assembler.
// The slave side is the assembler; the master side feeds beats and consumes tiles.
interface vector_tile_assembler_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] data_in  [0:7];
    logic                  valid_in;
    logic                  last_in;
    logic                  ready_in;
    logic [DATA_WIDTH-1:0] data_out [0:63];
    logic [6:0]            count_out;
    logic                  valid_out;
    logic                  ready_out;

    modport master (
        output data_in, valid_in, last_in, ready_out,
        input  ready_in, data_out, count_out, valid_out
    );

    modport slave (
        input  data_in, valid_in, last_in, ready_out,
        output ready_in, data_out, count_out, valid_out
    );
endinterface

// File: rtl/vector_tile_assembler.sv
// Collects 8-lane beats into 64-element tiles using two ping-pong banks, so one
// tile can fill while the other is held for the downstream slice unit.
module vector_tile_assembler #(
    parameter int DATA_WIDTH = 16,
    parameter int IN_LANES   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    vector_tile_assembler_if.slave bus
);
    localparam int TILE = IN_LANES * 8;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} bank_st_t;

    bank_st_t              st_q [2];
    bank_st_t              st_d [2];
    logic [DATA_WIDTH-1:0] bank [2][TILE];
    logic [6:0]            cnt  [2];
    logic                  fill_sel;
    logic                  drain_sel;
    logic [2:0]            beat_cnt;
    logic [3:0]            nbeats;
    logic                  accept;
    logic                  fill_done;
    logic                  drain;

    // ready_in looks only at registers so upstream may gate valid_in on it freely.
    assign bus.ready_in  = !rst && (st_q[fill_sel] == EMPTY);
    assign bus.valid_out = (st_q[drain_sel] == FULL);
    assign bus.count_out = bus.valid_out ? cnt[drain_sel] : 7'd0;

    assign accept    = bus.valid_in && bus.ready_in;
    assign fill_done = accept && ((beat_cnt == 3'd7) || bus.last_in);
    assign drain     = bus.valid_out && bus.ready_out;
    assign nbeats    = {1'b0, beat_cnt} + 4'd1;

    always_comb begin
        for (int i = 0; i < TILE; i++) bus.data_out[i] = bank[drain_sel][i];
    end

    // Fill and drain always target different banks, so both may fire together.
    always_comb begin
        st_d = st_q;
        if (fill_done) st_d[fill_sel]  = FULL;
        if (drain)     st_d[drain_sel] = EMPTY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q[0] <= EMPTY;
            st_q[1] <= EMPTY;
        end else begin
            st_q <= st_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < TILE; i++) bank[b][i] <= '0;
                cnt[b] <= 7'd0;
            end
            fill_sel  <= 1'b0;
            drain_sel <= 1'b0;
            beat_cnt  <= 3'd0;
        end else begin
            // Beat 0 wipes the rest of the bank so a short tile reads zero past its count.
            if (accept) begin
                for (int i = 0; i < TILE; i++) begin
                    if ((i / IN_LANES) == int'(beat_cnt))
                        bank[fill_sel][i] <= bus.data_in[i % IN_LANES];
                    else if (beat_cnt == 3'd0 && i >= IN_LANES)
                        bank[fill_sel][i] <= '0;
                end
            end
            if (fill_done) begin
                cnt[fill_sel] <= {nbeats, 3'b000};
                beat_cnt      <= 3'd0;
                fill_sel      <= ~fill_sel;
            end else if (accept) begin
                beat_cnt <= beat_cnt + 3'd1;
            end
            if (drain) drain_sel <= ~drain_sel;
        end
    end
endmodule

// File: tb/tb_vector_tile_assembler.sv
// Directed bench for vector_tile_assembler: expected tiles are queued as beats are
// issued, and a negedge monitor pops and compares on every output handshake.
module tb_vector_tile_assembler;
    localparam int DW = 16;

    typedef struct packed {
        logic [6:0]           cnt;
        logic [63:0][DW-1:0]  d;
    } tile_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vector_tile_assembler_if #(.DATA_WIDTH(DW)) bus ();
    vector_tile_assembler #(.DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int    tests  = 0;
    int    errors = 0;
    int    vcnt   = 0;
    tile_t expq[$];
    tile_t cur, snap, exp_t;
    bit    stalled = 0;
    bit    t3_done = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp_tile(string name, tile_t act, tile_t exp);
        int bad = -1;
        int bi;
        tests++;
        for (int i = 63; i >= 0; i--) if (act.d[i] !== exp.d[i]) bad = i;
        if (act.cnt !== exp.cnt || bad >= 0) begin
            errors++;
            bi = (bad < 0) ? 0 : bad;
            $display("FAIL %s: count %0d expected %0d, first bad element %0d got %0d expected %0d",
                     name, act.cnt, exp.cnt, bad, act.d[bi], exp.d[bi]);
        end
    endtask

    function automatic tile_t make_tile(int base, int nb);
        tile_t t;
        t.cnt = 7'(nb * 8);
        for (int i = 0; i < 64; i++) t.d[i] = (i < nb * 8) ? DW'(base + i) : '0;
        return t;
    endfunction

    // Monitor: hold-stability while stalled, scoreboard compare on handshake.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) cur.d[i] = bus.data_out[i];
            cur.cnt = bus.count_out;
            if (bus.valid_out) vcnt++;
            if (stalled && bus.valid_out) cmp_tile("hold_stable", cur, snap);
            if (bus.valid_out && bus.ready_out) begin
                if (expq.size() == 0) begin
                    tests++;
                    errors++;
                    $display("FAIL unexpected_tile: got count %0d expected no tile", cur.cnt);
                end else begin
                    exp_t = expq.pop_front();
                    cmp_tile("tile", cur, exp_t);
                end
            end
            stalled = bus.valid_out && !bus.ready_out;
            snap    = cur;
        end else begin
            stalled = 0;
        end
    end

    task automatic send_beat(int base, bit last);
        int n = 0;
        bit acc;
        bus.valid_in = 1'b1;
        bus.last_in  = last;
        for (int j = 0; j < 8; j++) bus.data_in[j] = DW'(base + j);
        do begin
            @(negedge clk);
            acc = bus.ready_in;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) begin
            tests++;
            errors++;
            $display("FAIL beat_timeout: got ready_in 0 for %0d cycles expected acceptance", n);
        end
        bus.valid_in = 1'b0;
        bus.last_in  = 1'b0;
    endtask

    task automatic send_tile(int base, int nb, bit last_on_final);
        expq.push_back(make_tile(base, nb));
        for (int k = 0; k < nb; k++)
            send_beat(base + 8 * k, (k == nb - 1) && (nb < 8 || last_on_final));
    endtask

    initial begin
        int v0;
        int nz;
        int n;
        bus.valid_in  = 1'b0;
        bus.last_in   = 1'b0;
        bus.ready_out = 1'b0;
        for (int j = 0; j < 8; j++) bus.data_in[j] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready_in", 32'(bus.ready_in), 0);
        chk("rst_valid_out", 32'(bus.valid_out), 0);
        chk("rst_count_out", 32'(bus.count_out), 0);
        nz = 0;
        for (int i = 0; i < 64; i++) if (bus.data_out[i] !== '0) nz++;
        chk("rst_data_out_nonzero", 32'(nz), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready_in", 32'(bus.ready_in), 1);
        @(posedge clk);
        #1;

        // Single full tile, valid exactly one cycle right after beat 7
        bus.ready_out = 1'b1;
        v0 = vcnt;
        send_tile(0, 8, 0);
        @(negedge clk);
        chk("t1_valid_after_last", 32'(bus.valid_out), 1);
        chk("t1_count", 32'(bus.count_out), 64);
        @(negedge clk);
        chk("t1_valid_dropped", 32'(bus.valid_out), 0);
        chk("t1_valid_cycles", 32'(vcnt - v0), 1);
        @(posedge clk);
        #1;

        // last_in on beat 7, then a short tile into a bank holding old data
        send_tile(1000, 8, 1);
        send_tile(2000, 3, 0);
        @(negedge clk);
        chk("t2_count24", 32'(bus.count_out), 24);
        chk("t2_elem23", 32'(bus.data_out[23]), 2023);
        chk("t2_elem24_zero", 32'(bus.data_out[24]), 0);
        chk("t2_elem63_zero", 32'(bus.data_out[63]), 0);
        @(posedge clk);
        #1;

        // Backpressure: two tiles fill both banks, third waits
        bus.ready_out = 1'b0;
        send_tile(3000, 8, 0);
        send_tile(4000, 8, 0);
        @(negedge clk);
        chk("t3_ready_low", 32'(bus.ready_in), 0);
        chk("t3_valid", 32'(bus.valid_out), 1);
        chk("t3_tile1_held", 32'(bus.data_out[5]), 3005);
        // valid_in activity while both banks are full
        repeat (12) begin
            bus.valid_in = 1'($urandom_range(0, 1));
            bus.last_in  = 1'($urandom_range(0, 1));
            for (int j = 0; j < 8; j++) bus.data_in[j] = DW'($urandom);
            @(negedge clk);
            chk("t3_ready_indep", 32'(bus.ready_in), 0);
        end
        bus.valid_in = 1'b0;
        bus.last_in  = 1'b0;
        @(posedge clk);
        #1;
        fork
            begin
                send_tile(5000, 8, 0);
                t3_done = 1;
            end
        join_none
        repeat (2) @(posedge clk);
        #1;
        bus.ready_out = 1'b1;
        @(posedge clk);
        #1;
        bus.ready_out = 1'b0;
        @(negedge clk);
        chk("t3_tile2_valid", 32'(bus.valid_out), 1);
        chk("t3_tile2_first", 32'(bus.data_out[0]), 4000);
        chk("t3_ready_back", 32'(bus.ready_in), 1);
        n = 0;
        while (!t3_done && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("t3_tile3_sent", 32'(t3_done), 1);
        bus.ready_out = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Final beat of B lands on the same edge as the handshake of A
        bus.ready_out = 1'b0;
        send_tile(6000, 8, 0);
        expq.push_back(make_tile(7000, 8));
        for (int k = 0; k < 7; k++) send_beat(7000 + 8 * k, 1'b0);
        bus.ready_out = 1'b1;
        send_beat(7056, 1'b0);
        @(negedge clk);
        chk("t4_no_bubble", 32'(bus.valid_out), 1);
        chk("t4_tileB_first", 32'(bus.data_out[0]), 7000);
        chk("t4_tileB_last", 32'(bus.data_out[63]), 7063);
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a tile while another tile is presented
        bus.ready_out = 1'b0;
        send_tile(8000, 8, 0);
        for (int k = 0; k < 5; k++) send_beat(9000 + 8 * k, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_ready_async", 32'(bus.ready_in), 0);
        chk("t5_valid_async", 32'(bus.valid_out), 0);
        chk("t5_count_async", 32'(bus.count_out), 0);
        chk("t5_data_async", 32'(bus.data_out[3]), 0);
        expq.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_ready_release", 32'(bus.ready_in), 1);
        @(posedge clk);
        #1;
        bus.ready_out = 1'b1;
        send_tile(10000, 8, 0);
        @(negedge clk);
        chk("t5_count", 32'(bus.count_out), 64);
        chk("t5_elem0", 32'(bus.data_out[0]), 10000);
        repeat (3) @(posedge clk);
        #1;

        chk("queue_empty", 32'(expq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
